ras_stack: RTL and testbench

- Return address stack for the fetch-stage branch predictor.
- Sits alongside the BTB, LHT and GBPT lookups.
- Push on predicted calls (link), pop on predicted returns; supplies the return target to the next-PC mux.
- Exports a checkpoint (stack pointer + count) with each prediction so the backend can restore the stack after a mispredict.

---
 rtl/ras_stack_pkg.sv | 46 ++++
 rtl/ras_stack.sv | 111 +++++++++++
 tb/tb_ras_stack.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ras_stack_pkg.sv
// rtl/ras_stack_pkg.sv - shared return-address-stack sizing, checkpoint and update types
package ras_stack_pkg;

    localparam int RAS_ENTRIES      = 8;
    localparam int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
    localparam int RAS_TARGET_WIDTH = 31;

    typedef logic [LOG_RAS_ENTRIES-1:0]  ras_index_t;
    typedef logic [LOG_RAS_ENTRIES:0]    ras_count_t;
    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

    // Snapshot carried with each prediction so branch resolution can rewind the stack.
    typedef struct packed {
        ras_index_t index;
        ras_count_t count;
    } ras_checkpoint_t;

    // One update kind per cycle, already resolved by priority.
    typedef enum logic [2:0] {
        RAS_OP_HOLD    = 3'd0,
        RAS_OP_RESTORE = 3'd1,
        RAS_OP_SWAP    = 3'd2,
        RAS_OP_PUSH    = 3'd3,
        RAS_OP_POP     = 3'd4
    } ras_op_e;

    // Restore beats everything; a call and return in the same cycle swap the top entry.
    function automatic ras_op_e ras_decode_op(input logic restore,
                                              input logic link,
                                              input logic ret);
        ras_op_e op;
        if (restore) begin
            op = RAS_OP_RESTORE;
        end else if (link && ret) begin
            op = RAS_OP_SWAP;
        end else if (link) begin
            op = RAS_OP_PUSH;
        end else if (ret) begin
            op = RAS_OP_POP;
        end else begin
            op = RAS_OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return address stack for the fetch-stage next-PC predictor
module ras_stack #(
    parameter int RAS_ENTRIES      = ras_stack_pkg::RAS_ENTRIES,
    parameter int LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = ras_stack_pkg::RAS_TARGET_WIDTH
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        link_valid_in,
    input  logic [RAS_TARGET_WIDTH-1:0] link_pc_in,
    input  logic                        ret_valid_in,
    output logic [RAS_TARGET_WIDTH-1:0] ret_pc_out,
    output logic                        ret_empty_out,
    output logic [LOG_RAS_ENTRIES-1:0]  ras_index_out,
    output logic [LOG_RAS_ENTRIES:0]    ras_count_out,
    input  logic                        restore_valid_in,
    input  logic [LOG_RAS_ENTRIES-1:0]  restore_ras_index_in,
    input  logic [LOG_RAS_ENTRIES:0]    restore_ras_count_in
);

    import ras_stack_pkg::*;

    localparam logic [LOG_RAS_ENTRIES:0]   CNT_FULL = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);
    localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE  = (LOG_RAS_ENTRIES+1)'(1);
    localparam logic [LOG_RAS_ENTRIES-1:0] PTR_ONE  = LOG_RAS_ENTRIES'(1);

    logic [RAS_TARGET_WIDTH-1:0] r_entries [RAS_ENTRIES];
    logic [LOG_RAS_ENTRIES-1:0]  r_ptr;
    logic [LOG_RAS_ENTRIES:0]    r_count;

    ras_op_e                     w_op;
    logic [LOG_RAS_ENTRIES-1:0]  w_ptr_inc;
    logic [LOG_RAS_ENTRIES-1:0]  w_ptr_dec;
    logic [LOG_RAS_ENTRIES:0]    w_count_inc;
    logic [LOG_RAS_ENTRIES:0]    w_restore_count;
    logic [LOG_RAS_ENTRIES-1:0]  w_ptr_nxt;
    logic [LOG_RAS_ENTRIES:0]    w_count_nxt;
    logic                        w_wr_en;
    logic [LOG_RAS_ENTRIES-1:0]  w_wr_idx;
    logic [RAS_TARGET_WIDTH-1:0] w_wr_data;

    assign w_op = ras_decode_op(restore_valid_in, link_valid_in, ret_valid_in);

    // Pointer wraps naturally at its width; count saturates at a full stack.
    assign w_ptr_inc       = r_ptr + PTR_ONE;
    assign w_ptr_dec       = r_ptr - PTR_ONE;
    assign w_count_inc     = (r_count >= CNT_FULL) ? CNT_FULL : (r_count + CNT_ONE);
    assign w_restore_count = (restore_ras_count_in > CNT_FULL) ? CNT_FULL : restore_ras_count_in;

    // Next pointer/count and the single entry write port, chosen by the resolved update kind.
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_ptr;
        w_wr_data   = link_pc_in;
        case (w_op)
            RAS_OP_RESTORE: begin
                w_ptr_nxt   = restore_ras_index_in;
                w_count_nxt = w_restore_count;
            end
            RAS_OP_SWAP: begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_ptr;
            end
            RAS_OP_PUSH: begin
                w_ptr_nxt   = w_ptr_inc;
                w_count_nxt = w_count_inc;
                w_wr_en     = 1'b1;
                w_wr_idx    = w_ptr_inc;
            end
            RAS_OP_POP: begin
                // Underflow leaves the stack untouched; consumers qualify with ret_empty_out.
                if (r_count != '0) begin
                    w_ptr_nxt   = w_ptr_dec;
                    w_count_nxt = r_count - CNT_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Checkpointable stack pointer and valid-entry count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Entry array; overflow silently overwrites the oldest slot.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_entries[w_wr_idx] <= w_wr_data;
        end
    end

    assign ret_pc_out    = r_entries[r_ptr];
    assign ret_empty_out = (r_count == '0);
    assign ras_index_out = r_ptr;
    assign ras_count_out = r_count;

endmodule

// File: tb/tb_ras_stack.sv
// tb/tb_ras_stack.sv - scoreboard testbench for ras_stack
module tb_ras_stack;

    logic        CLK;
    logic        nRST;
    logic        link_valid_in;
    logic [30:0] link_pc_in;
    logic        ret_valid_in;
    logic [30:0] ret_pc_out;
    logic        ret_empty_out;
    logic [2:0]  ras_index_out;
    logic [3:0]  ras_count_out;
    logic        restore_valid_in;
    logic [2:0]  restore_ras_index_in;
    logic [3:0]  restore_ras_count_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [30:0] pc;
        logic        empty;
        logic [2:0]  idx;
        logic [3:0]  cnt;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];

    ras_stack dut (
        .CLK                  (CLK),
        .nRST                 (nRST),
        .link_valid_in        (link_valid_in),
        .link_pc_in           (link_pc_in),
        .ret_valid_in         (ret_valid_in),
        .ret_pc_out           (ret_pc_out),
        .ret_empty_out        (ret_empty_out),
        .ras_index_out        (ras_index_out),
        .ras_count_out        (ras_count_out),
        .restore_valid_in     (restore_valid_in),
        .restore_ras_index_in (restore_ras_index_in),
        .restore_ras_count_in (restore_ras_count_in)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic clear_inputs();
        link_valid_in        = 1'b0;
        link_pc_in           = '0;
        ret_valid_in         = 1'b0;
        restore_valid_in     = 1'b0;
        restore_ras_index_in = '0;
        restore_ras_count_in = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // One clock of stimulus; outputs are observed 1 time unit after the edge.
    task automatic cyc(input logic link, input logic [30:0] pc, input logic ret,
                       input logic rst, input logic [2:0] ridx, input logic [3:0] rcnt);
        link_valid_in        = link;
        link_pc_in           = pc;
        ret_valid_in         = ret;
        restore_valid_in     = rst;
        restore_ras_index_in = ridx;
        restore_ras_count_in = rcnt;
        @(posedge CLK);
        #1;
        clear_inputs();
    endtask

    // Push the expected state and capture what the DUT shows right now.
    task automatic note(input string name, input logic [30:0] pc, input logic empty,
                        input logic [2:0] idx, input logic [3:0] cnt);
        rec_t e;
        rec_t g;
        e.name = name; e.pc = pc; e.empty = empty; e.idx = idx; e.cnt = cnt;
        g.name = name; g.pc = ret_pc_out; g.empty = ret_empty_out;
        g.idx = ras_index_out; g.cnt = ras_count_out;
        exp_q.push_back(e);
        got_q.push_back(g);
    endtask

    task automatic test_reset();
        rec_t e, g;
        do_reset();
        note("reset", 31'h0, 1'b1, 3'd0, 4'd0);
        cyc(1'b0, 31'h0, 1'b0, 1'b1, 3'd5, 4'd3);
        note("reset_entry5_zero", 31'h0, 1'b0, 3'd5, 4'd3);
        cyc(1'b0, 31'h0, 1'b0, 1'b1, 3'd0, 4'd15);
        note("restore_count_clamp", 31'h0, 1'b0, 3'd0, 4'd8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    task automatic test_push_pop();
        rec_t e, g;
        do_reset();
        cyc(1'b1, 31'h1000, 1'b0, 1'b0, 3'd0, 4'd0);
        note("push1", 31'h1000, 1'b0, 3'd1, 4'd1);
        cyc(1'b1, 31'h2000, 1'b0, 1'b0, 3'd0, 4'd0);
        note("push2", 31'h2000, 1'b0, 3'd2, 4'd2);
        cyc(1'b1, 31'h3000, 1'b0, 1'b0, 3'd0, 4'd0);
        note("push3", 31'h3000, 1'b0, 3'd3, 4'd3);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("pop1", 31'h2000, 1'b0, 3'd2, 4'd2);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("pop2", 31'h1000, 1'b0, 3'd1, 4'd1);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("pop3_empty", 31'h0, 1'b1, 3'd0, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    task automatic test_overflow();
        rec_t e, g;
        logic [3:0] c;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 31'h10 + 31'(i), 1'b0, 1'b0, 3'd0, 4'd0);
            c = (i + 1 > 8) ? 4'd8 : 4'(i + 1);
            note($sformatf("ovf_push%0d", i), 31'h10 + 31'(i), 1'b0, 3'(i + 1), c);
        end
        for (int i = 0; i < 8; i++) begin
            note($sformatf("ovf_top%0d", i), 31'h19 - 31'(i), 1'b0, 3'(2 - i), 4'(8 - i));
            cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        end
        note("ovf_drained", 31'h19, 1'b1, 3'd2, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    task automatic test_underflow();
        rec_t e, g;
        do_reset();
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("uf_reset_pop", 31'h0, 1'b1, 3'd0, 4'd0);
        cyc(1'b1, 31'h55, 1'b0, 1'b0, 3'd0, 4'd0);
        cyc(1'b0, 31'h0, 1'b0, 1'b1, 3'd1, 4'd0);
        note("uf_stale_setup", 31'h55, 1'b1, 3'd1, 4'd0);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("uf_pop1", 31'h55, 1'b1, 3'd1, 4'd0);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("uf_pop2", 31'h55, 1'b1, 3'd1, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    task automatic test_swap();
        rec_t e, g;
        do_reset();
        cyc(1'b1, 31'hA, 1'b0, 1'b0, 3'd0, 4'd0);
        note("swap_before", 31'hA, 1'b0, 3'd1, 4'd1);
        cyc(1'b1, 31'hB, 1'b1, 1'b0, 3'd0, 4'd0);
        note("swap_after", 31'hB, 1'b0, 3'd1, 4'd1);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("swap_pop", 31'h0, 1'b1, 3'd0, 4'd0);
        cyc(1'b1, 31'h77, 1'b1, 1'b0, 3'd0, 4'd0);
        note("swap_empty", 31'h77, 1'b1, 3'd0, 4'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    task automatic test_restore();
        rec_t e, g;
        do_reset();
        cyc(1'b1, 31'hA, 1'b0, 1'b0, 3'd0, 4'd0);
        note("ckpt_taken", 31'hA, 1'b0, 3'd1, 4'd1);
        cyc(1'b1, 31'hB, 1'b0, 1'b0, 3'd0, 4'd0);
        cyc(1'b1, 31'hC, 1'b0, 1'b0, 3'd0, 4'd0);
        note("rs_pushed", 31'hC, 1'b0, 3'd3, 4'd3);
        cyc(1'b1, 31'hD, 1'b0, 1'b1, 3'd1, 4'd1);
        note("rs_restored", 31'hA, 1'b0, 3'd1, 4'd1);
        cyc(1'b0, 31'h0, 1'b0, 1'b1, 3'd2, 4'd2);
        note("rs_no_d_slot2", 31'hB, 1'b0, 3'd2, 4'd2);
        cyc(1'b0, 31'h0, 1'b1, 1'b1, 3'd3, 4'd3);
        note("rs_ret_dropped", 31'hC, 1'b0, 3'd3, 4'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, g;
        do_reset();
        cyc(1'b1, 31'h1, 1'b0, 1'b0, 3'd0, 4'd0);
        cyc(1'b1, 31'h2, 1'b0, 1'b0, 3'd0, 4'd0);
        note("b2b_prefill", 31'h2, 1'b0, 3'd2, 4'd2);
        #2;
        nRST = 1'b0;
        #1;
        note("b2b_async_reset", 31'h0, 1'b1, 3'd0, 4'd0);
        #1;
        nRST = 1'b1;
        cyc(1'b1, 31'h3, 1'b0, 1'b0, 3'd0, 4'd0);
        note("b2b_after_reset", 31'h3, 1'b0, 3'd1, 4'd1);
        cyc(1'b1, 31'h21, 1'b0, 1'b0, 3'd0, 4'd0);
        note("b2b_push21", 31'h21, 1'b0, 3'd2, 4'd2);
        cyc(1'b1, 31'h22, 1'b0, 1'b0, 3'd0, 4'd0);
        note("b2b_push22", 31'h22, 1'b0, 3'd3, 4'd3);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("b2b_pop", 31'h21, 1'b0, 3'd2, 4'd2);
        cyc(1'b1, 31'h23, 1'b0, 1'b0, 3'd0, 4'd0);
        note("b2b_push23", 31'h23, 1'b0, 3'd3, 4'd3);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("b2b_pop2", 31'h21, 1'b0, 3'd2, 4'd2);
        cyc(1'b0, 31'h0, 1'b1, 1'b0, 3'd0, 4'd0);
        note("b2b_pop3", 31'h3, 1'b0, 3'd1, 4'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.pc !== e.pc || g.empty !== e.empty || g.idx !== e.idx || g.cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got pc=%h empty=%b idx=%0d cnt=%0d want pc=%h empty=%b idx=%0d cnt=%0d",
                         e.name, g.pc, g.empty, g.idx, g.cnt, e.pc, e.empty, e.idx, e.cnt);
            end
        end
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b0;
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_swap();
        test_restore();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
